// File: rtl/reg_swap_seq.sv
// Register-file sequencer: single-cycle writes and three-step swaps of two
// registers through an external combinational-read register file.
module reg_swap_seq #(
  parameter int pw = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  input  logic [1:0]    req_op,
  input  logic [pw-1:0] req_addrA,
  input  logic [pw-1:0] req_addrB,
  input  logic [7:0]    req_data,
  output logic          req_ready,
  output logic [pw:0]   rf_rd_addrA,
  output logic [pw:0]   rf_rd_addrB,
  input  logic [7:0]    datA_in,
  input  logic [7:0]    datB_in,
  output logic          rf_wr_en,
  output logic [pw:0]   rf_wr_addr,
  output logic [7:0]    rf_dat_out,
  output logic          done,
  output logic [7:0]    swap_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    CAPT  = 3'd2,
    WR_A  = 3'd3,
    WR_B  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          accept_s;
  logic [pw-1:0] addr_a_r;
  logic [pw-1:0] addr_b_r;
  logic [7:0]    tmp_a_r;
  logic          ready_r;
  logic          wr_en_r;
  logic [pw:0]   wr_addr_r;
  logic [7:0]    dat_r;
  logic          done_r;
  logic [7:0]    cnt_r;
  logic          wr_en_nxt_s;
  logic [pw:0]   wr_addr_nxt_s;
  logic [7:0]    dat_nxt_s;
  logic          done_nxt_s;

  // Next-state and next registered write-port values
  always_comb begin
    state_nxt_s   = state_r;
    accept_s      = 1'b0;
    wr_en_nxt_s   = 1'b0;
    done_nxt_s    = 1'b0;
    wr_addr_nxt_s = wr_addr_r;
    dat_nxt_s     = dat_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          case (req_op)
            2'b00: begin
              state_nxt_s   = WRITE;
              wr_en_nxt_s   = 1'b1;
              wr_addr_nxt_s = {1'b0, req_addrA};
              dat_nxt_s     = req_data;
              done_nxt_s    = 1'b1;
            end
            2'b01: begin
              state_nxt_s = CAPT;
            end
            default: begin
              state_nxt_s = WRITE;
              done_nxt_s  = 1'b1;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        state_nxt_s = IDLE;
      end
      // rf_dat_out itself carries tmpB through WR_A
      CAPT: begin
        state_nxt_s   = WR_A;
        wr_en_nxt_s   = 1'b1;
        wr_addr_nxt_s = {1'b0, addr_a_r};
        dat_nxt_s     = datB_in;
      end
      WR_A: begin
        state_nxt_s   = WR_B;
        wr_en_nxt_s   = 1'b1;
        wr_addr_nxt_s = {1'b0, addr_b_r};
        dat_nxt_s     = tmp_a_r;
        done_nxt_s    = 1'b1;
      end
      WR_B: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Read pointers follow the live request while idle, the latched pair otherwise
  always_comb begin
    rf_rd_addrA = {1'b0, addr_a_r};
    rf_rd_addrB = {1'b0, addr_b_r};
    if (state_r == IDLE) begin
      rf_rd_addrA = {1'b0, req_addrA};
      rf_rd_addrB = {1'b0, req_addrB};
    end else begin
      rf_rd_addrA = {1'b0, addr_a_r};
      rf_rd_addrB = {1'b0, addr_b_r};
    end
  end

  // State register and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Request latches, swap temporary, write port, done pulse and swap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_a_r  <= '0;
      addr_b_r  <= '0;
      tmp_a_r   <= 8'd0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      dat_r     <= 8'd0;
      done_r    <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      if (accept_s) begin
        addr_a_r <= req_addrA;
        addr_b_r <= req_addrB;
      end
      if (state_r == CAPT) begin
        tmp_a_r <= datA_in;
      end
      if (state_r == WR_B) begin
        cnt_r <= cnt_r + 8'd1;
      end
      wr_en_r   <= wr_en_nxt_s;
      wr_addr_r <= wr_addr_nxt_s;
      dat_r     <= dat_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign req_ready  = ready_r;
  assign rf_wr_en   = wr_en_r;
  assign rf_wr_addr = wr_addr_r;
  assign rf_dat_out = dat_r;
  assign done       = done_r;
  assign swap_cnt   = cnt_r;

endmodule

// File: tb/tb_reg_swap_seq.sv
// Bench for reg_swap_seq: external register file, transaction-level model
// of expected output beats, per-cycle compare plus directed literal checks.
module tb_reg_swap_seq;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'b00;
  logic [PW-1:0] req_addrA = '0;
  logic [PW-1:0] req_addrB = '0;
  logic [7:0]    req_data = 8'd0;
  logic          req_ready;
  logic [PW:0]   rf_rd_addrA, rf_rd_addrB;
  logic [7:0]    datA_in, datB_in;
  logic          rf_wr_en;
  logic [PW:0]   rf_wr_addr;
  logic [7:0]    rf_dat_out;
  logic          done;
  logic [7:0]    swap_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic rf_init = 1'b1;
  logic [7:0] tb_rf [16];
  logic [7:0] snap [16];

  reg_swap_seq #(.pw(PW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_addrA(req_addrA), .req_addrB(req_addrB), .req_data(req_data),
    .req_ready(req_ready), .rf_rd_addrA(rf_rd_addrA), .rf_rd_addrB(rf_rd_addrB),
    .datA_in(datA_in), .datB_in(datB_in), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_dat_out(rf_dat_out), .done(done),
    .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    logic [3:0] n;
    n = i[3:0];
    return (i == 5) ? 8'h7F : {n, n};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // The register file the DUT drives
  assign datA_in = tb_rf[rf_rd_addrA[PW-1:0]];
  assign datB_in = tb_rf[rf_rd_addrB[PW-1:0]];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) tb_rf[i] <= init_val(i);
    end else if (rf_wr_en) begin
      tb_rf[rf_wr_addr[PW-1:0]] <= rf_dat_out;
    end
  end

  // Model: each accepted request expands into the list of cycles it occupies
  typedef struct packed {
    logic       active;
    logic       wen;
    logic [3:0] addr;
    logic [7:0] dat;
    logic       done;
    logic       inc;
  } beat_t;

  beat_t      m_q [$];
  beat_t      m_cur = '0;
  beat_t      m_hold;
  logic [7:0] m_rf [16];
  logic [7:0] m_cnt = 8'd0;
  logic [3:0] m_lat_a = '0;
  logic [3:0] m_lat_b = '0;
  logic       exp_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cur = '0;
      m_cnt = 8'd0;
      m_lat_a = '0;
      m_lat_b = '0;
      if (rf_init) for (int i = 0; i < 16; i++) m_rf[i] = init_val(i);
    end else begin
      if (m_cur.wen) m_rf[m_cur.addr] = m_cur.dat;
      if (m_cur.inc) m_cnt = m_cnt + 8'd1;
      if (m_q.size() == 0 && !m_cur.active && req_valid) begin
        m_lat_a = req_addrA;
        m_lat_b = req_addrB;
        m_hold = '{1'b1, 1'b0, m_cur.addr, m_cur.dat, 1'b0, 1'b0};
        if (req_op == 2'b00) begin
          m_q.push_back('{1'b1, 1'b1, req_addrA, req_data, 1'b1, 1'b0});
        end else if (req_op == 2'b01) begin
          m_q.push_back(m_hold);
          m_q.push_back('{1'b1, 1'b1, req_addrA, m_rf[req_addrB], 1'b0, 1'b0});
          m_q.push_back('{1'b1, 1'b1, req_addrB, m_rf[req_addrA], 1'b1, 1'b1});
        end else begin
          m_hold.done = 1'b1;
          m_q.push_back(m_hold);
        end
      end
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
      end else begin
        m_cur.active = 1'b0;
        m_cur.wen = 1'b0;
        m_cur.done = 1'b0;
        m_cur.inc = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    exp_rdy = (m_q.size() == 0) && !m_cur.active;
    chk("req_ready", req_ready, exp_rdy);
    chk("rf_wr_en", rf_wr_en, m_cur.wen);
    chk("rf_wr_addr", rf_wr_addr, {1'b0, m_cur.addr});
    chk("rf_dat_out", rf_dat_out, m_cur.dat);
    chk("done", done, m_cur.done);
    chk("swap_cnt", swap_cnt, m_cnt);
    chk("rf_rd_addrA", rf_rd_addrA, exp_rdy ? {1'b0, req_addrA} : {1'b0, m_lat_a});
    chk("rf_rd_addrB", rf_rd_addrB, exp_rdy ? {1'b0, req_addrB} : {1'b0, m_lat_b});
  end

  task automatic accept(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] d);
    int k;
    @(negedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addrA = a; req_addrB = b; req_data = d;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("ready_timeout", req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int diffs;
    logic [7:0] s6, s9;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", rf_wr_en, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr_addr", rf_wr_addr, 5'd0);
    chk("rst_dat", rf_dat_out, 8'd0);
    chk("rst_cnt", swap_cnt, 8'd0);
    #1; rst_n = 1'b1; rf_init = 1'b0;

    accept(2'b00, 4'd3, 4'd0, 8'h5A);
    wait_done(lat);
    chk("wr_latency", lat, 32'd1);
    chk("wr_en", rf_wr_en, 1'b1);
    chk("wr_addr", rf_wr_addr, 5'd3);
    chk("wr_dat", rf_dat_out, 8'h5A);
    @(negedge clk); #1;
    chk("wr_ready_after", req_ready, 1'b1);

    accept(2'b01, 4'd1, 4'd2, 8'h00);
    wait_done(lat);
    chk("swap_latency", lat, 32'd3);
    chk("swap_wrb_addr", rf_wr_addr, 5'd2);
    chk("swap_wrb_dat", rf_dat_out, 8'h11);
    @(negedge clk); #1;
    chk("swap_r1", tb_rf[1], 8'h22);
    chk("swap_r2", tb_rf[2], 8'h11);
    chk("swap_cnt1", swap_cnt, 8'd1);

    accept(2'b01, 4'd5, 4'd5, 8'h00);
    wait_done(lat);
    chk("same_latency", lat, 32'd3);
    chk("same_dat", rf_dat_out, 8'h7F);
    @(negedge clk); #1;
    chk("same_r5", tb_rf[5], 8'h7F);
    chk("same_cnt", swap_cnt, 8'd2);

    for (int i = 0; i < 16; i++) snap[i] = tb_rf[i];
    accept(2'b11, 4'd7, 4'd8, 8'hAA);
    wait_done(lat);
    chk("nop_latency", lat, 32'd1);
    chk("nop_wr_en", rf_wr_en, 1'b0);
    @(negedge clk); #1;
    diffs = 0;
    for (int i = 0; i < 16; i++) if (tb_rf[i] !== snap[i]) diffs++;
    chk("nop_rf_unchanged", diffs, 32'd0);

    // Busy-time requests with changing fields must be ignored
    @(negedge clk); #1;
    req_valid = 1'b1; req_op = 2'b01; req_addrA = 4'd3; req_addrB = 4'd4; req_data = 8'h00;
    chk("hold_ready0", req_ready, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      req_op = 2'b00; req_addrA = 4'(8 + i); req_addrB = 4'(i); req_data = 8'(8'hC0 + i);
      chk("hold_not_ready", req_ready, 1'b0);
    end
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    chk("hold_r3", tb_rf[3], 8'h44);
    chk("hold_r4", tb_rf[4], 8'h5A);
    chk("hold_r8", tb_rf[8], 8'h88);
    chk("hold_cnt", swap_cnt, 8'd3);

    for (int i = 0; i < 256; i++) begin
      accept(2'b01, 4'(i), 4'(i + 7), 8'h00);
      wait_done(lat);
      chk("loop_latency", lat, 32'd3);
    end
    @(negedge clk); #1;
    chk("wrap_cnt", swap_cnt, 8'd3);
    for (int i = 0; i < 16; i++) chk("rf_vs_model", tb_rf[i], m_rf[i]);

    // Asynchronous reset in the middle of WR_A
    s6 = tb_rf[6];
    s9 = tb_rf[9];
    accept(2'b01, 4'd6, 4'd9, 8'h00);
    @(negedge clk); #2;
    chk("abort_wra_en", rf_wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", rf_wr_en, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_cnt", swap_cnt, 8'd0);
    chk("abort_ready", req_ready, 1'b1);
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_r6", tb_rf[6], s6);
    chk("abort_r9", tb_rf[9], s9);
    chk("abort_cnt_after", swap_cnt, 8'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
